// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sequencer: FSM states, default timing
// parameters and the letter-to-pattern table.
package morse_pkg;

  localparam int TICK_DIV_DEFAULT  = 25_000_000;
  localparam int GAP_TICKS_DEFAULT = 3;
  localparam int PATTERN_BITS      = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef logic [PATTERN_BITS-1:0] pattern_t;

  // Patterns play MSB first; index is the 3-bit letter code.
  localparam pattern_t LETTER_TABLE [8] = '{
    14'b10101000000000,
    14'b11100000000000,
    14'b10101110000000,
    14'b10101011100000,
    14'b10111011100000,
    14'b11101010111000,
    14'b11101011101110,
    14'b11101110101000
  };

  function automatic logic [2:0] letter_code(input logic [11:0] msg,
                                             input logic [1:0]  idx);
    case (idx)
      2'd0:    return msg[2:0];
      2'd1:    return msg[5:3];
      2'd2:    return msg[8:6];
      default: return msg[11:9];
    endcase
  endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Request/status bundle between a message source and the Morse sequencer.
interface morse_sequencer_if;

  logic        start;
  logic        abort;
  logic [11:0] msg;
  logic [1:0]  msg_len;
  logic        led;
  logic        busy;
  logic        done;
  logic [1:0]  letter_idx;

  modport master (
    output start, abort, msg, msg_len,
    input  led, busy, done, letter_idx
  );

  modport slave (
    input  start, abort, msg, msg_len,
    output led, busy, done, letter_idx
  );

endinterface

// File: rtl/morse_tick_gen.sv
// Bit-period divider: counts 0..TICK_DIV-1 and flags the wrap cycle.
module morse_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/morse_sequencer.sv
// Plays up to four Morse letters on led, one pattern bit per TICK_DIV cycles,
// with GAP_TICKS zero periods between letters.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  morse_sequencer_if.slave   bus
);

  localparam logic [3:0] LAST_BIT = 4'(PATTERN_BITS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

  state_t      state;
  pattern_t    pattern;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [11:0] msg_q;
  logic [1:0]  len_q;
  logic [1:0]  letter_idx;
  logic        led;
  logic        busy;
  logic        done;

  logic        tick;
  logic        tick_clear;
  logic [1:0]  next_idx;
  pattern_t    start_pattern;
  pattern_t    next_pattern;

  assign next_idx      = letter_idx + 2'd1;
  assign start_pattern = LETTER_TABLE[bus.msg[2:0]];
  assign next_pattern  = LETTER_TABLE[letter_code(msg_q, next_idx)];

  // Each letter starts its first bit period on a fresh count.
  assign tick_clear = (state == IDLE) ||
                      (state == GAP && tick && gap_cnt == GAP_LAST);

  morse_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      pattern    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      msg_q      <= '0;
      len_q      <= '0;
      letter_idx <= '0;
      led        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start && !bus.abort) begin
            state      <= SHIFT;
            msg_q      <= bus.msg;
            len_q      <= bus.msg_len;
            pattern    <= start_pattern;
            led        <= start_pattern[PATTERN_BITS-1];
            busy       <= 1'b1;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            letter_idx <= '0;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              led     <= 1'b0;
              bit_cnt <= '0;
              if (letter_idx < len_q) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              pattern <= pattern << 1;
              led     <= pattern[PATTERN_BITS-2];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state      <= SHIFT;
              letter_idx <= next_idx;
              pattern    <= next_pattern;
              led        <= next_pattern[PATTERN_BITS-1];
              gap_cnt    <= '0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led        = led;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.letter_idx = letter_idx;

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: expected waveforms are expanded
// from the letter table and timing rules, then compared cycle by cycle.
module tb_morse_sequencer;

  localparam int TD = 4;
  localparam int GT = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  morse_sequencer_if io ();

  morse_sequencer #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GT)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (io)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         busy_seen;
  logic [1:0] idx_steps[$];

  function automatic logic [13:0] ref_pattern(input logic [2:0] code);
    case (code)
      3'd0:    return 14'b10101000000000;
      3'd1:    return 14'b11100000000000;
      3'd2:    return 14'b10101110000000;
      3'd3:    return 14'b10101011100000;
      3'd4:    return 14'b10111011100000;
      3'd5:    return 14'b11101010111000;
      3'd6:    return 14'b11101011101110;
      default: return 14'b11101110101000;
    endcase
  endfunction

  // Plays one message. abort_at / reset_at (0 = unused) interrupt playback
  // during that cycle; disturb scrambles msg inputs and re-pulses start.
  task automatic run_msg(input logic [11:0] m, input logic [1:0] len,
                         input int abort_at, input int reset_at,
                         input bit disturb, input string name);
    logic        led_q[$];
    logic [1:0]  idx_q[$];
    logic [13:0] pat;
    logic        exp_led, exp_busy, exp_done, bad;
    logic [1:0]  exp_idx;
    int          n;

    for (int l = 0; l <= int'(len); l++) begin
      pat = ref_pattern(m[3*l +: 3]);
      for (int b = 13; b >= 0; b--)
        repeat (TD) begin
          led_q.push_back(pat[b]);
          idx_q.push_back(2'(l));
        end
      if (l < int'(len))
        repeat (GT * TD) begin
          led_q.push_back(1'b0);
          idx_q.push_back(2'(l));
        end
    end
    n = led_q.size();
    busy_seen = 0;
    idx_steps.delete();

    @(negedge clk);
    io.start = 1'b1; io.abort = 1'b0; io.msg = m; io.msg_len = len;
    @(negedge clk);
    io.start = 1'b0;

    for (int cyc = 1; cyc <= n + 1; cyc++) begin
      exp_busy = (cyc <= n);
      exp_done = (cyc == n + 1);
      exp_led  = (cyc <= n) ? led_q[cyc-1] : 1'b0;
      exp_idx  = (cyc <= n) ? idx_q[cyc-1] : 2'd0;
      bad = (io.led !== exp_led) || (io.busy !== exp_busy) ||
            (io.done !== exp_done) || (exp_busy && io.letter_idx !== exp_idx);
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got led=%b busy=%b done=%b idx=%0d, want led=%b busy=%b done=%b idx=%0d",
                 name, cyc, io.led, io.busy, io.done, io.letter_idx,
                 exp_led, exp_busy, exp_done, exp_idx);
      end
      if (io.busy === 1'b1) begin
        busy_seen++;
        if (idx_steps.size() == 0 || idx_steps[$] !== io.letter_idx)
          idx_steps.push_back(io.letter_idx);
      end

      if (disturb) begin
        io.msg     = 12'($urandom);
        io.msg_len = 2'($urandom_range(0, 3));
        io.start   = (cyc == 10);
      end

      if (cyc == abort_at || cyc == reset_at) begin
        if (cyc == abort_at) io.abort = 1'b1;
        else                 rst = 1'b1;
        @(negedge clk);
        io.abort = 1'b0; rst = 1'b0; io.start = 1'b0;
        tests_run++;
        if ({io.led, io.busy, io.done} !== 3'b000 ||
            (cyc == reset_at && io.letter_idx !== 2'd0)) begin
          tests_failed++;
          $display("FAIL %s interrupt@%0d: got led=%b busy=%b done=%b idx=%0d, want all 0",
                   name, cyc, io.led, io.busy, io.done, io.letter_idx);
        end
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          tests_run++;
          if ({io.led, io.busy, io.done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s post-interrupt +%0d: got led=%b busy=%b done=%b, want 0 0 0",
                     name, i + 2, io.led, io.busy, io.done);
          end
        end
        return;
      end
      @(negedge clk);
    end

    io.start = 1'b0;
    tests_run++;
    if ({io.led, io.busy, io.done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s after done: got led=%b busy=%b done=%b, want 0 0 0",
               name, io.led, io.busy, io.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.start = 1'($urandom); io.abort = 1'($urandom); io.msg = 12'($urandom);
    end
    @(negedge clk);
    tests_run++;
    if ({io.led, io.busy, io.done, io.letter_idx} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got led=%b busy=%b done=%b idx=%0d, want all 0",
               io.led, io.busy, io.done, io.letter_idx);
    end
    io.start = 1'b0; io.abort = 1'b0; rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({io.led, io.busy, io.done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_release: got led=%b busy=%b done=%b, want 0 0 0",
               io.led, io.busy, io.done);
    end
  endtask

  task automatic test_single_letter();
    run_msg(12'b000_000_000_001, 2'd0, 0, 0, 1'b0, "single_001");
    tests_run++;
    if (busy_seen != 14 * TD) begin
      tests_failed++;
      $display("FAIL single_busy_len: got %0d, want %0d", busy_seen, 14 * TD);
    end
  endtask

  task automatic test_two_letters();
    run_msg(12'b000_000_001_000, 2'd1, 0, 0, 1'b0, "two_000_001");
  endtask

  task automatic test_ignore_start();
    run_msg(12'b011_101_010_100, 2'd2, 0, 0, 1'b1, "ignore_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_msg(12'($urandom), 2'($urandom_range(0, 3)), 0, 0, 1'b1, "random");
  endtask

  task automatic test_abort();
    run_msg(12'b000_000_111_101, 2'd1, 20, 0, 1'b0, "abort_20");
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    io.start = 1'b1; io.abort = 1'b1; io.msg = 12'h5a5; io.msg_len = 2'd3;
    @(negedge clk);
    io.start = 1'b0; io.abort = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if ({io.led, io.busy, io.done} !== 3'b000) begin
        tests_failed++;
        $display("FAIL start_abort_idle cycle %0d: got led=%b busy=%b done=%b, want 0 0 0",
                 i, io.led, io.busy, io.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midplay();
    run_msg(12'b000_000_001_000, 2'd1, 0, 30, 1'b0, "reset_mid_letter");
    run_msg(12'b000_000_001_000, 2'd1, 0, 62, 1'b0, "reset_mid_gap");
    run_msg(12'b000_000_010_110, 2'd1, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_four_letters();
    run_msg({4{3'b110}}, 2'd3, 0, 0, 1'b0, "four_110");
    tests_run++;
    if (busy_seen != 4 * 14 * TD + 3 * GT * TD) begin
      tests_failed++;
      $display("FAIL four_busy_len: got %0d, want %0d", busy_seen, 4 * 14 * TD + 3 * GT * TD);
    end
    tests_run++;
    if (idx_steps.size() != 4 || idx_steps[0] !== 2'd0 || idx_steps[1] !== 2'd1 ||
        idx_steps[2] !== 2'd2 || idx_steps[3] !== 2'd3) begin
      tests_failed++;
      $display("FAIL four_idx_steps: got %0d distinct steps, want 0,1,2,3", idx_steps.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io.start = 1'b0; io.abort = 1'b0; io.msg = '0; io.msg_len = '0;
    test_reset();
    test_single_letter();
    test_two_letters();
    test_ignore_start();
    test_random();
    test_abort();
    test_start_abort_idle();
    test_reset_midplay();
    test_four_letters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
